// File: rtl/pe_load_buffer.sv
// Per-PE writable word store: zero-cleared by a sweep after reset/clr, then loaded from a
// shared, PE-ID-filtered load bus. Single registered read port, read-first on collisions.
module pe_load_buffer #(
  parameter int unsigned addrLen = 10,
  parameter int unsigned dataLen = 16,
  parameter int unsigned peId    = 0,
  parameter int unsigned peIdLen = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [peIdLen-1:0] ld_pe_id,
  input  logic [dataLen-1:0] ld_data,
  input  logic               ld_last,
  input  logic               rd_en,
  input  logic [addrLen-1:0] rd_addr,
  output logic [dataLen-1:0] data_out,
  output logic               rd_valid,
  output logic               busy,
  output logic [addrLen:0]   load_count,
  output logic               overflow
);

  localparam int unsigned DEPTH = 1 << addrLen;
  localparam int unsigned CntW  = addrLen + 1;

  typedef enum logic [1:0] {StClear, StIdle, StLoad} state_e;

  state_e               state_q, state_d;
  logic [addrLen-1:0]   cptr_q, cptr_d;
  logic [CntW-1:0]      wptr_q, wptr_d;
  logic [CntW-1:0]      load_count_q, load_count_d;
  logic                 overflow_q, overflow_d;
  logic [dataLen-1:0]   data_out_q, data_out_d;
  logic                 rd_valid_q, rd_valid_d;

  logic [dataLen-1:0]   mem_q [DEPTH];
  logic                 mem_we;
  logic [addrLen-1:0]   mem_waddr;
  logic [dataLen-1:0]   mem_wdata;

  logic                 accept;
  logic                 match;

  assign busy       = reset || (state_q == StClear);
  assign ld_ready   = !busy;
  assign accept     = ld_valid && ld_ready;
  // Non-matching beats are still accepted so other PEs on the bus never stall.
  assign match      = accept && (ld_pe_id == peIdLen'(peId));
  assign data_out   = data_out_q;
  assign rd_valid   = rd_valid_q;
  assign load_count = load_count_q;
  assign overflow   = overflow_q;

  always_comb begin
    state_d      = state_q;
    cptr_d       = cptr_q;
    wptr_d       = wptr_q;
    load_count_d = load_count_q;
    overflow_d   = overflow_q;
    mem_we       = 1'b0;
    mem_waddr    = '0;
    mem_wdata    = '0;

    if (clr) begin
      // clr wins over a simultaneous beat and aborts any burst.
      state_d      = StClear;
      cptr_d       = '0;
      load_count_d = '0;
      overflow_d   = 1'b0;
    end else begin
      unique case (state_q)
        StClear: begin
          mem_we    = 1'b1;
          mem_waddr = cptr_q;
          cptr_d    = cptr_q + 1'b1;
          if (cptr_q == {addrLen{1'b1}}) begin
            state_d = StIdle;
          end
        end
        StIdle: begin
          if (match) begin
            mem_we       = 1'b1;
            mem_waddr    = '0;
            mem_wdata    = ld_data;
            wptr_d       = CntW'(1);
            load_count_d = CntW'(1);
            overflow_d   = 1'b0;
            if (!ld_last) begin
              state_d = StLoad;
            end
          end
        end
        StLoad: begin
          if (match) begin
            if (wptr_q < CntW'(DEPTH)) begin
              mem_we       = 1'b1;
              mem_waddr    = wptr_q[addrLen-1:0];
              mem_wdata    = ld_data;
              wptr_d       = wptr_q + 1'b1;
              load_count_d = load_count_q + 1'b1;
            end else begin
              overflow_d = 1'b1;
            end
            if (ld_last) begin
              state_d = StIdle;
            end
          end
        end
        default: state_d = StClear;
      endcase
    end
  end

  always_comb begin
    rd_valid_d = rd_en;
    data_out_d = data_out_q;
    if (rd_en) begin
      data_out_d = (state_q == StClear) ? '0 : mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StClear;
      cptr_q       <= '0;
      wptr_q       <= '0;
      load_count_q <= '0;
      overflow_q   <= 1'b0;
      data_out_q   <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cptr_q       <= cptr_d;
      wptr_q       <= wptr_d;
      load_count_q <= load_count_d;
      overflow_q   <= overflow_d;
      data_out_q   <= data_out_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_pe_load_buffer.sv
// Directed bench for pe_load_buffer: read expectations go through a scoreboard queue that a
// negedge monitor drains whenever rd_valid is high; control outputs are checked directly.
module tb_pe_load_buffer;

  localparam int unsigned AddrLen = 3;
  localparam int unsigned DataLen = 16;
  localparam int unsigned PeIdLen = 6;
  localparam int unsigned Depth   = 1 << AddrLen;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               clr = 1'b0;
  logic               ld_valid = 1'b0;
  logic               ld_ready;
  logic [PeIdLen-1:0] ld_pe_id = '0;
  logic [DataLen-1:0] ld_data = '0;
  logic               ld_last = 1'b0;
  logic               rd_en = 1'b0;
  logic [AddrLen-1:0] rd_addr = '0;
  logic [DataLen-1:0] data_out;
  logic               rd_valid;
  logic               busy;
  logic [AddrLen:0]   load_count;
  logic               overflow;

  int unsigned compared = 0;
  int unsigned errors   = 0;
  logic [DataLen-1:0] exp_q [$];

  pe_load_buffer #(
    .addrLen(AddrLen),
    .dataLen(DataLen),
    .peId   (3),
    .peIdLen(PeIdLen)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_pe_id  (ld_pe_id),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .data_out  (data_out),
    .rd_valid  (rd_valid),
    .busy      (busy),
    .load_count(load_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Monitor: every rd_valid must consume exactly one queued expectation.
  always @(negedge clk) begin
    if (rd_valid) begin
      compared++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL read_unexpected: rd_valid high with data %0h, required no read", data_out);
      end else begin
        logic [DataLen-1:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          errors++;
          $display("FAIL read_data: got %0h, required %0h", data_out, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic beat(input int unsigned pe, input int unsigned data, input bit last);
    ld_valid = 1'b1;
    ld_pe_id = PeIdLen'(pe);
    ld_data  = DataLen'(data);
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // Queue the expectation for a read issued on the coming edge.
  task automatic issue_rd(input int unsigned addr, input int unsigned exp);
    rd_en   = 1'b1;
    rd_addr = AddrLen'(addr);
    exp_q.push_back(DataLen'(exp));
  endtask

  task automatic rd(input int unsigned addr, input int unsigned exp);
    issue_rd(addr, exp);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic count_busy(input string name, input int unsigned exp);
    int unsigned cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      tick();
    end
    check(name, cnt, exp);
  endtask

  initial begin
    // Reset and sweep
    tick();
    tick();
    check("reset_busy", busy, 1);
    check("reset_ld_ready", ld_ready, 0);
    check("reset_load_count", load_count, 0);
    check("reset_overflow", overflow, 0);
    check("reset_rd_valid", rd_valid, 0);
    check("reset_data_out", data_out, 0);
    reset = 1'b0;
    count_busy("sweep_busy_cycles", Depth);
    check("sweep_ld_ready", ld_ready, 1);
    rd(5, 16'h0000);

    // Filtered load with interleaved beats for PE 7
    beat(3, 16'h00A1, 0);
    check("load_count_first", load_count, 1);
    beat(7, 16'h00FF, 0);
    beat(3, 16'h00A2, 0);
    beat(7, 16'h00EE, 1);
    beat(3, 16'h00A3, 1);
    check("filt_load_count", load_count, 3);
    check("filt_overflow", overflow, 0);
    rd(0, 16'h00A1);
    rd(1, 16'h00A2);
    rd(2, 16'h00A3);
    rd(3, 16'h0000);

    // Read-write collision on address 2 returns the old word
    beat(3, 16'h0011, 0);
    beat(3, 16'h0022, 0);
    issue_rd(2, 16'h00A3);
    beat(3, 16'h0055, 1);
    rd_en = 1'b0;
    rd(2, 16'h0055);
    check("coll_load_count", load_count, 3);

    // Back-to-back reads, held rd_en
    issue_rd(3, 16'h0000);
    tick();
    issue_rd(2, 16'h0055);
    tick();
    issue_rd(1, 16'h0022);
    tick();
    issue_rd(0, 16'h0011);
    tick();
    rd_en = 1'b0;
    tick();
    check("hold_rd_valid", rd_valid, 0);
    check("hold_data_out", data_out, 16'h0011);

    // Overflow: DEPTH+2 beats
    for (int i = 1; i <= Depth + 2; i++) begin
      beat(3, i, i == Depth + 2);
      if (i == Depth + 1) begin
        check("ovf_set_at_beat", overflow, 1);
        check("ovf_count_sat", load_count, Depth);
      end
    end
    check("ovf_load_count", load_count, Depth);
    check("ovf_overflow", overflow, 1);
    for (int a = 0; a < Depth; a++) begin
      rd(a, a + 1);
    end
    beat(3, 16'h0009, 1);
    check("ovf_new_overflow", overflow, 0);
    check("ovf_new_load_count", load_count, 1);
    rd(0, 16'h0009);
    rd(1, 16'h0002);

    // clr mid-burst: third beat dropped
    beat(3, 16'h0071, 0);
    beat(3, 16'h0072, 0);
    clr = 1'b1;
    beat(3, 16'h0073, 0);
    clr = 1'b0;
    check("clr_busy", busy, 1);
    check("clr_ld_ready", ld_ready, 0);
    check("clr_load_count", load_count, 0);
    rd(1, 16'h0000);
    count_busy("clr_busy_cycles", Depth - 1);
    check("clr_done_ld_ready", ld_ready, 1);
    for (int a = 0; a < Depth; a++) begin
      rd(a, 16'h0000);
    end
    check("clr_final_load_count", load_count, 0);
    check("clr_final_overflow", overflow, 0);

    tick();
    tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
    $finish;
  end

endmodule

// File: doc/pe_load_buffer.md
# pe_load_buffer

Writable, parametrised successor to the per-PE constant buffer. Each PE instance holds a `2^addrLen`-deep word store that is zero-cleared after reset and then loaded at run time from a shared load bus, filtered by `peId`. Reads use a registered single-cycle port. It replaces hard-coded per-PE contents with contents that can be reprogrammed between runs without resynthesis.

## Interface
- `addrLen`, 10, address width; `DEPTH = 2^addrLen`.
- `dataLen`, 16, word width.
- `peId`, 0, ID of this PE instance.
- `peIdLen`, 6, width of the PE ID field on the load bus.

- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `clr`  in  1  pulse; restarts the zero-clear sweep.
- `ld_valid`  in  1  load beat is valid.
- `ld_ready`  out  1  buffer can accept a load beat.
- `ld_pe_id`  in  `peIdLen`  destination PE ID for the beat.
- `ld_data`  in  `dataLen`  load word.
- `ld_last`  in  1  last beat of the burst for this destination.
- `rd_en`  in  1  read request.
- `rd_addr`  in  `addrLen`  read address.
- `data_out`  out  `dataLen`  registered read data.
- `rd_valid`  out  1  `data_out` was updated by a read on this cycle.
- `busy`  out  1  clear sweep is in progress.
- `load_count`  out  `addrLen+1`  words written in the current or most recent burst.
- `overflow`  out  1  sticky: the burst exceeded `DEPTH`.

## Operation
- States:
  - CLEAR: entered on `reset`, and on `clr` from any state. On each cycle, writes 0 to `mem[cptr]` and increments `cptr`. After the write to `DEPTH-1`, goes to IDLE. Entering CLEAR sets `cptr=0`, `load_count=0`, `overflow=0`.
  - IDLE: waits for a load beat.
  - LOAD: a burst is in progress.
- A beat is accepted when `ld_valid && ld_ready`. `ld_ready = (state != CLEAR)`.
- A beat matches when it is accepted and `ld_pe_id == peId`. Accepted beats that do not match are dropped with no state change. This keeps the shared bus from stalling on other PEs.
- Matching beat in IDLE:
  - Writes `mem[0]`, sets `wptr=1` and `load_count=1`, clears `overflow`.
  - Goes to LOAD, or stays in IDLE if `ld_last` is set.
- Matching beat in LOAD:
  - If `wptr < DEPTH`: writes `mem[wptr]`, then `wptr++` and `load_count++`.
  - Otherwise the data is dropped and `overflow` is set to 1.
  - If `ld_last` is set: returns to IDLE; `load_count` holds its value.
- `wptr` never wraps. `load_count` saturates at `DEPTH`.
- `clr` takes priority over a simultaneous load beat; the beat is dropped. `clr` in LOAD aborts the burst.
- Reads are allowed in every state.
  - In CLEAR, a read returns 0.
  - Otherwise it returns `mem[rd_addr]`.
  - A read and a write to the same address in the same cycle return the old data (read-first).

## Timing
- Values during and at the cycle after `reset`: `data_out=0`, `rd_valid=0`, `ld_ready=0`, `busy=1`, `load_count=0`, `overflow=0`, state CLEAR, `cptr=0`.
- `reset` mid-burst or mid-sweep restarts CLEAR; memory contents are re-zeroed.
- Clear sweep takes exactly `DEPTH` cycles after the first edge with `reset=0`. `busy` and `!ld_ready` last exactly `DEPTH` cycles. `ld_ready` rises on the following cycle.
- `clr` sampled high at edge N: `busy=1` from edge N for `DEPTH` cycles. A `clr` during CLEAR restarts the sweep at `cptr=0`.
- Read latency is 1 cycle. `rd_en` sampled at edge N gives `data_out` and `rd_valid=1` after edge N.
- With `rd_en=0`: `rd_valid=0` and `data_out` holds its last value.
- A write at edge N is visible to a read sampled at edge N+1 or later.
- `load_count` and `overflow` update at the same edge as the beat that changes them.

## Test plan
- **Reset and sweep** (`addrLen=4`): release reset → `busy=1`, `ld_ready=0` for 16 cycles, then `ld_ready=1`. Read address 5 → `data_out=0`, `rd_valid=1` one cycle after `rd_en`.
- **Filtered load** (`peId=3`): beats with `ld_pe_id=3`, data 0xA1, 0xA2, 0xA3 (last), interleaved with beats for `ld_pe_id=7` → reads at addresses 0/1/2 return 0xA1/0xA2/0xA3, address 3 returns 0, `load_count=3`, `overflow=0`.
- **Overflow** (`addrLen=2`): burst of 6 matching beats 1..6, last on beat 6 → `mem` = {1,2,3,4}, `load_count=4`, `overflow=1`. A new 1-beat burst (value 9) → `overflow=0`, `load_count=1`, `mem[0]=9`.
- **Read-write collision**: write 0x55 to address 2 while reading address 2 in the same cycle → `data_out` shows the old value. Next read of address 2 → 0x55.
- **`clr` mid-burst**: 2 beats accepted, then `clr` together with a third beat → third beat dropped, sweep runs for `DEPTH` cycles, every address reads 0, `load_count=0`.
- **Back-to-back reads**: `rd_en` held high over addresses 0..3 after a load → `rd_valid` high continuously, and `data_out` follows each address one cycle later.
